// File: rtl/min_sec_counter_if.sv
// -----------------------------------------------------------------------------
// min_sec_counter_if
// Groups the button inputs and time/mode outputs of the seconds/minutes
// timebase into one bundle.
//   master : drives mode_btn/inc_btn, observes seconds/minutes/min_tick/mode
//   slave  : the counter itself (receives buttons, drives time and mode)
// Ports carried:
//   mode_btn  1  debounced mode button level
//   inc_btn   1  debounced increment button level
//   seconds   6  current seconds
//   minutes   6  current minutes
//   min_tick  1  hour carry to the downstream hours counter
//   mode      2  00=RUN, 01=SET_MIN, 10=SET_HR
// -----------------------------------------------------------------------------
interface min_sec_counter_if;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       min_tick;
    logic [1:0] mode;

    modport master (
        output mode_btn,
        output inc_btn,
        input  seconds,
        input  minutes,
        input  min_tick,
        input  mode
    );

    modport slave (
        input  mode_btn,
        input  inc_btn,
        output seconds,
        output minutes,
        output min_tick,
        output mode
    );
endinterface

// File: rtl/min_sec_counter.sv
// -----------------------------------------------------------------------------
// min_sec_counter
// Seconds/minutes timebase for a 24-hour clock with a button-driven set mode.
// In RUN it counts seconds and minutes on every clk_1Hz edge; in SET_MIN each
// inc_btn press advances minutes; in SET_HR each press emits one min_tick so
// the downstream hours counter advances.
// Ports:
//   clk_1Hz  in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   bus      slave modport of min_sec_counter_if (buttons in; seconds,
//            minutes, min_tick, mode out)
// -----------------------------------------------------------------------------
module min_sec_counter #(
    parameter int unsigned SEC_MOD = 60,
    parameter int unsigned MIN_MOD = 60
) (
    input  logic                  clk_1Hz,
    input  logic                  rst,
    min_sec_counter_if.slave      bus
);

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_MIN = 2'b01,
        MODE_SET_HR  = 2'b10,
        MODE_BAD     = 2'b11
    } mode_t;

    localparam logic [5:0] SEC_LAST = 6'(SEC_MOD - 32'd1);
    localparam logic [5:0] MIN_LAST = 6'(MIN_MOD - 32'd1);

    // Modular increment: wraps to zero at the last legal value, so a field
    // can never step outside its range.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
        logic [5:0] r;
        if (v >= last) begin
            r = 6'd0;
        end else begin
            r = v + 6'd1;
        end
        return r;
    endfunction

    mode_t      mode_q, mode_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic       mode_btn_q, mode_btn_d;
    logic       inc_btn_q, inc_btn_d;
    logic       mode_rise;
    logic       inc_rise;
    logic       tick_run;
    logic       tick_set;

    // Next-state logic: button edge detect, mode FSM and time fields.
    always_comb begin
        mode_d     = mode_q;
        sec_d      = sec_q;
        min_d      = min_q;
        mode_btn_d = bus.mode_btn;
        inc_btn_d  = bus.inc_btn;
        mode_rise  = bus.mode_btn & ~mode_btn_q;
        inc_rise   = bus.inc_btn & ~inc_btn_q;

        case (mode_q)
            MODE_RUN: begin
                // Minutes keep their normal carry even on the edge that
                // enters SET_MIN, so they stay coherent with min_tick.
                if (sec_q == SEC_LAST) begin
                    sec_d = 6'd0;
                    min_d = wrap_inc(min_q, MIN_LAST);
                end else begin
                    sec_d = sec_q + 6'd1;
                    min_d = min_q;
                end
                if (mode_rise) begin
                    mode_d = MODE_SET_MIN;
                    sec_d  = 6'd0;
                end else begin
                    mode_d = MODE_RUN;
                end
            end
            MODE_SET_MIN: begin
                sec_d = 6'd0;
                // A mode press on the same edge wins; the increment is lost.
                if (mode_rise) begin
                    mode_d = MODE_SET_HR;
                    min_d  = min_q;
                end else if (inc_rise) begin
                    mode_d = MODE_SET_MIN;
                    min_d  = wrap_inc(min_q, MIN_LAST);
                end else begin
                    mode_d = MODE_SET_MIN;
                    min_d  = min_q;
                end
            end
            MODE_SET_HR: begin
                sec_d = 6'd0;
                min_d = min_q;
                if (mode_rise) begin
                    mode_d = MODE_RUN;
                end else begin
                    mode_d = MODE_SET_HR;
                end
            end
            default: begin
                // Illegal encoding: fall back to RUN with a clean seconds field.
                mode_d = MODE_RUN;
                sec_d  = 6'd0;
                min_d  = min_q;
            end
        endcase

        // Hour carry is high in the cycle before minutes wrap so hours and
        // minutes roll on the same edge; set-mode pulses last one cycle
        // because inc_rise clears once inc_btn_q catches up.
        tick_run = (mode_q == MODE_RUN) && (sec_q == SEC_LAST) && (min_q == MIN_LAST);
        tick_set = (mode_q == MODE_SET_HR) && inc_rise && !mode_rise;
    end

    // State registers; button history preloads to 1 so a button held
    // through reset release is not seen as a press.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_RUN;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            mode_btn_q <= 1'b1;
            inc_btn_q  <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            mode_btn_q <= mode_btn_d;
            inc_btn_q  <= inc_btn_d;
        end
    end

    assign bus.seconds  = sec_q;
    assign bus.minutes  = min_q;
    assign bus.mode     = mode_q;
    assign bus.min_tick = tick_run | tick_set;

endmodule

// File: tb/tb_min_sec_counter.sv
// -----------------------------------------------------------------------------
// tb_min_sec_counter
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a monitor process pops and compares each entry on the falling edge
// of the cycle it is due. A small hours-counter model consumes min_tick.
// -----------------------------------------------------------------------------
module tb_min_sec_counter;

    typedef struct {
        string      name;
        int         due;
        logic [5:0] sec;
        logic [5:0] min;
        logic       tick;
        logic [1:0] mode;
        bit         chk_hr;
        logic [4:0] hr;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    logic [4:0] hours_q;
    exp_t sb_q[$];

    min_sec_counter_if bus ();

    min_sec_counter #(
        .SEC_MOD(60),
        .MIN_MOD(60)
    ) dut (
        .clk_1Hz (clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to schedule scoreboard entries.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream hours counter model driven by min_tick.
    initial hours_q = 5'd23;
    always @(posedge clk) begin
        if (!rst && bus.min_tick) begin
            hours_q <= (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        end
    end

    // Wait for the next rising edge, then drive the button levels that the
    // following edge will sample.
    task automatic step(input logic mb, input logic ib);
        @(posedge clk);
        #2;
        bus.mode_btn = mb;
        bus.inc_btn  = ib;
    endtask

    // Queue an expectation for the current cycle.
    task automatic expect_st(input string name, input int sec, input int min,
                             input bit tick, input int mode,
                             input bit chk_hr, input int hr);
        exp_t e;
        e.name   = name;
        e.due    = cyc;
        e.sec    = 6'(sec);
        e.min    = 6'(min);
        e.tick   = tick;
        e.mode   = 2'(mode);
        e.chk_hr = chk_hr;
        e.hr     = 5'(hr);
        sb_q.push_back(e);
    endtask

    // Monitor: compare due entries against the DUT on the falling edge.
    initial begin
        exp_t e;
        bit   ok;
        n_checks = 0;
        n_pass   = 0;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_checks++;
                ok = (e.due == cyc) &&
                     (bus.seconds == e.sec) && (bus.minutes == e.min) &&
                     (bus.min_tick == e.tick) && (bus.mode == e.mode) &&
                     (!e.chk_hr || (hours_q == e.hr));
                if (ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got sec=%0d min=%0d tick=%0d mode=%0d hr=%0d, expected sec=%0d min=%0d tick=%0d mode=%0d hr=%0d%s",
                             e.name, bus.seconds, bus.minutes, bus.min_tick, bus.mode, hours_q,
                             e.sec, e.min, e.tick, e.mode, e.hr,
                             (e.due == cyc) ? "" : " (not sampled in its cycle)");
                end
            end
        end
    end

    initial begin
        int ms[3];
        rst          = 1'b1;
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;

        // Reset state and release.
        step(1'b0, 1'b0);
        expect_st("rst_hold", 0, 0, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        expect_st("rst_release", 0, 0, 1'b0, 0, 1'b0, 0);

        // Free run up to 1:01 past the hour wrap.
        for (int k = 1; k <= 3601; k++) begin
            step(1'b0, 1'b0);
            if (k == 59)   expect_st("run_59s", 59, 0, 1'b0, 0, 1'b0, 0);
            if (k == 60)   expect_st("run_sec_wrap", 0, 1, 1'b0, 0, 1'b0, 0);
            if (k == 61)   expect_st("run_61", 1, 1, 1'b0, 0, 1'b0, 0);
            if (k == 3598) expect_st("pre_tick", 58, 59, 1'b0, 0, 1'b1, 23);
            if (k == 3599) expect_st("tick_5959", 59, 59, 1'b1, 0, 1'b1, 23);
            if (k == 3600) expect_st("hour_wrap", 0, 0, 1'b0, 0, 1'b1, 0);
            if (k == 3601) expect_st("after_wrap", 1, 0, 1'b0, 0, 1'b1, 0);
        end

        // Enter SET_MIN with the button pressed at seconds=37.
        for (int k = 3602; k <= 3636; k++) begin
            step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        expect_st("mode_press_37", 37, 0, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0);
        expect_st("enter_set_min", 0, 0, 1'b0, 1, 1'b0, 0);

        // Bring minutes to 58, then three presses across the wrap.
        repeat (58) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        expect_st("set_min_58", 0, 58, 1'b0, 1, 1'b0, 0);
        ms[0] = 59; ms[1] = 0; ms[2] = 1;
        for (int p = 0; p < 3; p++) begin
            step(1'b0, 1'b1);
            expect_st($sformatf("set_min_press%0d", p), 0, (p == 0) ? 58 : ms[p-1], 1'b0, 1, 1'b1, 0);
            step(1'b0, 1'b0);
            expect_st($sformatf("set_min_inc%0d", p), 0, ms[p], 1'b0, 1, 1'b1, 0);
        end

        // Simultaneous mode and inc presses: mode wins.
        step(1'b1, 1'b1);
        expect_st("simul_press", 0, 1, 1'b0, 1, 1'b0, 0);
        step(1'b0, 1'b0);
        expect_st("simul_result", 0, 1, 1'b0, 2, 1'b1, 0);

        // Four single-cycle hour pulses in SET_HR.
        for (int p = 0; p < 4; p++) begin
            step(1'b0, 1'b1);
            expect_st($sformatf("set_hr_tick%0d", p), 0, 1, 1'b1, 2, 1'b1, p);
            step(1'b0, 1'b0);
            expect_st($sformatf("set_hr_after%0d", p), 0, 1, 1'b0, 2, 1'b1, p + 1);
        end

        // Held inc button gives one pulse only.
        step(1'b0, 1'b1);
        expect_st("held_first", 0, 1, 1'b1, 2, 1'b1, 4);
        step(1'b0, 1'b1);
        expect_st("held_second", 0, 1, 1'b0, 2, 1'b1, 5);
        step(1'b0, 1'b1);
        expect_st("held_third", 0, 1, 1'b0, 2, 1'b1, 5);
        step(1'b0, 1'b0);
        expect_st("held_release", 0, 1, 1'b0, 2, 1'b1, 5);

        // Async reset between edges in SET_HR with both buttons held.
        @(posedge clk);
        #2;
        bus.mode_btn = 1'b1;
        bus.inc_btn  = 1'b1;
        rst          = 1'b1;
        #1;
        expect_st("async_rst", 0, 0, 1'b0, 0, 1'b1, 5);
        #5;
        rst = 1'b0;

        // Held buttons across release produce no edges.
        step(1'b1, 1'b1);
        expect_st("post_rst_held1", 1, 0, 1'b0, 0, 1'b1, 5);
        step(1'b1, 1'b1);
        expect_st("post_rst_held2", 2, 0, 1'b0, 0, 1'b1, 5);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        expect_st("post_rst_press", 4, 0, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0);
        expect_st("post_rst_set_min", 0, 0, 1'b0, 1, 1'b0, 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        expect_st("post_rst_inc", 0, 1, 1'b0, 1, 1'b0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb_q.size() > 0) begin
            $display("FAIL drain: got %0d entries left unchecked, expected 0", sb_q.size());
            n_checks = n_checks + sb_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
